// File: rtl/addsub_pipe_if.sv
// addsub_pipe_if
// Handshake bundle for the pipelined adder/subtractor.
//   Request side : in_valid, in_ready, a, b, op, cin
//   Response side: out_valid, out_ready, sum, cout, ovf, zero, neg
// The master modport belongs to whoever issues operations and consumes
// results. The slave modport belongs to the arithmetic block.
interface addsub_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, a, b, op, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero, neg
  );

  modport slave (
    input  in_valid, a, b, op, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, neg
  );
endinterface

// File: rtl/addsub_pipe.sv
// addsub_pipe
// Pipelined WIDTH-bit adder/subtractor. The carry chain is cut into STAGES
// equal segments with a register between each segment. Accepts one
// operation per cycle under valid/ready. The whole pipe stalls on output
// backpressure, and results leave in issue order.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - addsub_pipe_if slave:
//          in_valid/in_ready, a, b, op, cin (request);
//          out_valid/out_ready, sum, cout, ovf, zero, neg (response).
//   op encoding: 00 ADD, 01 SUB, 10 ADC, 11 SBC.
module addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  addsub_pipe_if.slave bus
);

  localparam int SEG = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $fatal(1, "addsub_pipe: WIDTH must be >= 2 and a multiple of STAGES (1 <= STAGES <= WIDTH)");
  end

  logic             advance;
  logic             take;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Slot k holds the operation that has finished segment k. Operands are
  // carried whole so higher segments are still available to later stages.
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] carry_q;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  res_q [STAGES];
  logic              ovf_q;
  logic              zero_q;
  logic              neg_q;

  logic [STAGES-1:0] carry_nxt;
  logic [WIDTH-1:0]  a_nxt   [STAGES];
  logic [WIDTH-1:0]  b_nxt   [STAGES];
  logic [WIDTH-1:0]  res_nxt [STAGES];
  logic [SEG:0]      seg_sum [STAGES];
  logic              carry_msb;

  // A stall freezes every slot, bubbles included, so ready depends only on
  // the output register.
  assign advance      = !valid_q[STAGES-1] || bus.out_ready;
  assign take         = bus.in_valid && advance;
  assign bus.in_ready = advance;

  assign b_eff = bus.op[0] ? ~bus.b : bus.b;
  assign c0    = bus.op[1] ? bus.cin : bus.op[0];

  always_comb begin
    // Stage 0 works directly on the incoming operands.
    a_nxt[0]   = bus.a;
    b_nxt[0]   = b_eff;
    seg_sum[0] = {1'b0, bus.a[SEG-1:0]} + {1'b0, b_eff[SEG-1:0]} + {{SEG{1'b0}}, c0};
    res_nxt[0] = '0;
    res_nxt[0][SEG-1:0] = seg_sum[0][SEG-1:0];
    carry_nxt[0] = seg_sum[0][SEG];

    for (int k = 1; k < STAGES; k++) begin
      a_nxt[k]   = a_q[k-1];
      b_nxt[k]   = b_q[k-1];
      seg_sum[k] = {1'b0, a_q[k-1][k*SEG +: SEG]} + {1'b0, b_q[k-1][k*SEG +: SEG]}
                   + {{SEG{1'b0}}, carry_q[k-1]};
      res_nxt[k] = res_q[k-1];
      res_nxt[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
      carry_nxt[k] = seg_sum[k][SEG];
    end

    // The sum bit at the MSB is a ^ b ^ carry-in, so the carry into the MSB
    // can be recovered from the bits that are already there.
    carry_msb = a_nxt[STAGES-1][WIDTH-1] ^ b_nxt[STAGES-1][WIDTH-1]
                ^ res_nxt[STAGES-1][WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (advance) begin
      valid_q[0] <= take;
      for (int k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_nxt[k];
        b_q[k]   <= b_nxt[k];
        res_q[k] <= res_nxt[k];
      end
      carry_q <= carry_nxt;
      ovf_q   <= carry_msb ^ carry_nxt[STAGES-1];
      zero_q  <= (res_nxt[STAGES-1] == '0);
      neg_q   <= res_nxt[STAGES-1][WIDTH-1];
    end
  end

  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.sum       = res_q[STAGES-1];
  assign bus.cout      = carry_q[STAGES-1];
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe
// Self-checking bench for addsub_pipe. The main instance (WIDTH=32,
// STAGES=4) gets directed vectors with literal expectations plus a random
// phase. An arithmetic model and scoreboard check every result. Extra
// instances with STAGES 1, 2, 8 and 32 share the same input stream with
// out_ready tied high, and are checked for value and exact latency.
module tb_addsub_pipe;

  localparam int W = 32;
  localparam int S = 4;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBC = 2'b11;

  logic clk;
  logic rst;
  int   n_compared;
  int   n_mismatched;
  int   cyc;

  addsub_pipe_if #(.WIDTH(W)) bif ();

  addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Result packed as {cout, ovf, zero, neg, sum}, computed from plain
  // unsigned and signed integer arithmetic.
  function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] op, input logic cin);
    logic [W-1:0] be;
    logic         c;
    logic [W:0]   full;
    logic [W-1:0] s;
    longint       sv;
    logic         ovf;
    be   = op[0] ? ~b : b;
    c    = op[1] ? cin : op[0];
    full = {1'b0, a} + {1'b0, be} + (W+1)'(c);
    s    = full[W-1:0];
    sv   = longint'($signed(a)) + longint'($signed(be)) + longint'(c);
    ovf  = (sv != longint'($signed(s)));
    return {full[W], ovf, (s == '0), s[W-1], s};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                               input logic [1:0] op_i, input logic cin_i, input logic rdy);
    bif.in_valid  = v;
    bif.a         = a_i;
    bif.b         = b_i;
    bif.op        = op_i;
    bif.cin       = cin_i;
    bif.out_ready = rdy;
  endtask

  // Scoreboard for the main instance: expected results in issue order.
  logic [W+3:0] exp_q[$];

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      checkOutput("in_ready_rule", bif.in_ready, !bif.out_valid || bif.out_ready);
      if (bif.out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("valid_without_op", bif.out_valid, 1'b0);
        end else begin
          checkOutput("result", {bif.cout, bif.ovf, bif.zero, bif.neg, bif.sum}, exp_q[0]);
          if (bif.out_ready) void'(exp_q.pop_front());
        end
      end
      if (bif.in_valid && bif.in_ready) exp_q.push_back(model(bif.a, bif.b, bif.op, bif.cin));
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int SS = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 32;
    addsub_pipe_if #(.WIDTH(W)) sif ();
    logic [W+3:0] q[$];
    int           tq[$];

    assign sif.in_valid  = bif.in_valid;
    assign sif.a         = bif.a;
    assign sif.b         = bif.b;
    assign sif.op        = bif.op;
    assign sif.cin       = bif.cin;
    assign sif.out_ready = 1'b1;

    addsub_pipe #(.WIDTH(W), .STAGES(SS)) dut_s (
      .clk (clk),
      .rst (rst),
      .bus (sif)
    );

    // Accepted before edge n+1 means visible after edge n+SS, i.e. SS
    // negedges later.
    always @(negedge clk) begin
      if (rst) begin
        q.delete();
        tq.delete();
      end else begin
        if (sif.out_valid || (q.size() > 0 && cyc - tq[0] >= SS)) begin
          if (q.size() == 0) begin
            checkOutput($sformatf("sweep_s%0d_valid_without_op", SS), sif.out_valid, 1'b0);
          end else begin
            checkOutput($sformatf("sweep_s%0d_valid", SS), sif.out_valid, 1'b1);
            checkOutput($sformatf("sweep_s%0d_latency", SS), cyc - tq[0], SS);
            checkOutput($sformatf("sweep_s%0d_result", SS),
                        {sif.cout, sif.ovf, sif.zero, sif.neg, sif.sum}, q[0]);
            void'(q.pop_front());
            void'(tq.pop_front());
          end
        end
        if (sif.in_valid && sif.in_ready) begin
          q.push_back(model(sif.a, sif.b, sif.op, sif.cin));
          tq.push_back(cyc);
        end
      end
    end
  end

  // One isolated operation on an empty pipe, checked against literals.
  task automatic runSingle(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] op, input logic cin, input logic [W-1:0] e_sum,
                           input logic e_cout, input logic e_ovf, input logic e_zero,
                           input logic e_neg);
    checkOutput({name, "_model"}, model(a, b, op, cin), {e_cout, e_ovf, e_zero, e_neg, e_sum});
    @(posedge clk);
    #1 applyStimulus(1'b1, a, b, op, cin, 1'b1);
    @(posedge clk);
    #1 applyStimulus(1'b0, '0, '0, OP_ADD, 1'b0, 1'b1);
    for (int k = 0; k < S; k++) begin
      @(negedge clk);
      checkOutput({name, "_valid"}, bif.out_valid, (k == S - 1));
    end
    checkOutput({name, "_sum"}, bif.sum, e_sum);
    checkOutput({name, "_cout"}, bif.cout, e_cout);
    checkOutput({name, "_ovf"}, bif.ovf, e_ovf);
    checkOutput({name, "_zero"}, bif.zero, e_zero);
    checkOutput({name, "_neg"}, bif.neg, e_neg);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic exp_v;
    logic took;
    int   idx;
    int   budget;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    n_compared   = 0;
    n_mismatched = 0;
    cyc          = 0;
    rst          = 1'b1;
    applyStimulus(1'b0, '0, '0, OP_ADD, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_out_valid", bif.out_valid, 1'b0);
    checkOutput("rst_in_ready", bif.in_ready, 1'b1);
    checkOutput("rst_sum", bif.sum, '0);
    checkOutput("rst_flags", {bif.cout, bif.ovf, bif.zero, bif.neg}, 4'b0000);

    $display("[TB] single operations");
    runSingle("add_wrap", 32'hFFFFFFFF, 32'h00000001, OP_ADD, 1'b0, 32'h00000000, 1, 0, 1, 0);
    runSingle("sub_ovf", 32'h80000000, 32'h00000001, OP_SUB, 1'b0, 32'h7FFFFFFF, 1, 1, 0, 0);
    runSingle("sub_borrow", 32'h00000000, 32'h00000001, OP_SUB, 1'b0, 32'hFFFFFFFF, 0, 0, 0, 1);
    runSingle("adc_seg", 32'h0000FFFF, 32'h00000000, OP_ADC, 1'b1, 32'h00010000, 0, 0, 0, 0);
    runSingle("sbc_5_3", 32'h00000005, 32'h00000003, OP_SBC, 1'b0, 32'h00000001, 1, 0, 0, 0);
    runSingle("add_ign_cin", 32'h00000002, 32'h00000003, OP_ADD, 1'b1, 32'h00000005, 0, 0, 0, 0);
    runSingle("sub_zero", 32'h00000007, 32'h00000007, OP_SUB, 1'b0, 32'h00000000, 1, 0, 1, 0);
    runSingle("add_pos_ovf", 32'h7FFFFFFF, 32'h00000001, OP_ADD, 1'b0, 32'h80000000, 0, 1, 0, 1);

    // Eight back-to-back ADDs of a=t, b=100: results after edges 3..10.
    $display("[TB] back-to-back");
    @(posedge clk);
    #1 applyStimulus(1'b1, 32'd0, 32'd100, OP_ADD, 1'b0, 1'b1);
    for (int t = 0; t < 12; t++) begin
      @(posedge clk);
      #1;
      if (t + 1 < 8) applyStimulus(1'b1, W'(t + 1), 32'd100, OP_ADD, 1'b0, 1'b1);
      else           applyStimulus(1'b0, '0, '0, OP_ADD, 1'b0, 1'b1);
      @(negedge clk);
      exp_v = (t >= 3 && t <= 10);
      checkOutput("b2b_valid", bif.out_valid, exp_v);
      if (exp_v) checkOutput("b2b_sum", bif.sum, W'(100 + t - 3));
    end

    // Op, bubble, op: valid pattern 1,0,1 at the output.
    $display("[TB] bubble");
    @(posedge clk);
    #1 applyStimulus(1'b1, 32'd1, 32'd1, OP_ADD, 1'b0, 1'b1);
    for (int t = 0; t < 7; t++) begin
      @(posedge clk);
      #1;
      if (t == 1) applyStimulus(1'b1, 32'd2, 32'd2, OP_ADD, 1'b0, 1'b1);
      else        applyStimulus(1'b0, '0, '0, OP_ADD, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("bubble_valid", bif.out_valid, (t == 3 || t == 5));
      if (t == 3) checkOutput("bubble_sum0", bif.sum, 32'd2);
      if (t == 5) checkOutput("bubble_sum1", bif.sum, 32'd4);
    end

    // Seven ADDs of a=idx, b=1000 with in_valid held; out_ready low for
    // three cycles once the first result is at the output.
    $display("[TB] stall");
    @(posedge clk);
    #1 idx = 0;
    applyStimulus(1'b1, 32'd0, 32'd1000, OP_ADD, 1'b0, 1'b1);
    @(negedge clk);
    took = bif.in_valid && bif.in_ready;
    for (int t = 0; t < 17; t++) begin
      @(posedge clk);
      #1;
      if (took) idx++;
      applyStimulus(idx < 7, W'(idx), 32'd1000, OP_ADD, 1'b0, !(t >= 3 && t <= 5));
      @(negedge clk);
      if (t >= 3 && t <= 6) begin
        checkOutput("stall_out_valid", bif.out_valid, 1'b1);
        checkOutput("stall_sum", bif.sum, 32'd1000);
      end
      if (t >= 3 && t <= 5) checkOutput("stall_in_ready", bif.in_ready, 1'b0);
      took = bif.in_valid && bif.in_ready;
    end
    checkOutput("stall_all_issued", idx, 7);
    checkOutput("stall_all_delivered", exp_q.size(), 0);

    // Three operations in flight, then reset: nothing may come out.
    $display("[TB] reset flush");
    @(posedge clk);
    #1 applyStimulus(1'b1, 32'd0, 32'd7, OP_ADD, 1'b0, 1'b1);
    for (int t = 0; t < 3; t++) begin
      @(posedge clk);
      #1;
      if (t < 2) begin
        applyStimulus(1'b1, W'(t + 1), 32'd7, OP_ADD, 1'b0, 1'b1);
      end else begin
        applyStimulus(1'b0, '0, '0, OP_ADD, 1'b0, 1'b1);
        rst = 1'b1;
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      checkOutput("flush_out_valid", bif.out_valid, 1'b0);
      @(posedge clk);
      #1;
    end
    checkOutput("flush_sum", bif.sum, '0);

    $display("[TB] random phase");
    for (int t = 0; t < 400; t++) begin
      @(posedge clk);
      #1;
      case ($urandom_range(0, 4))
        0:       ra = 32'hFFFFFFFF;
        1:       ra = 32'h80000000;
        2:       ra = 32'h7FFFFFFF;
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 3) == 0) ? 32'h00000001 : $urandom;
      applyStimulus($urandom_range(0, 9) < 7, ra, rb, 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
    end

    @(posedge clk);
    #1 applyStimulus(1'b0, '0, '0, OP_ADD, 1'b0, 1'b1);
    budget = 0;
    while (exp_q.size() != 0 && budget < 64) begin
      @(posedge clk);
      budget++;
    end
    repeat (40) @(posedge clk);
    checkOutput("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
